// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with per-bit toggle, binary up/down count and parallel load.
// q, tc and chg are registered one edge after sampling; en=0 holds q.
module t_ff_bank #(
  parameter int          WIDTH   = 8,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] chg
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_RESET = RST_VAL[WIDTH-1:0];

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             tc_q, tc_d;

  assign mode_sel = mode_e'(mode);

  // Ripple-toggle counting is the same as +/-1; the carry out is the wrap.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_TOGGLE: q_d = q_q ^ t;
        MODE_UP: begin
          q_d  = q_q + ONE;
          tc_d = &q_q;
        end
        MODE_DOWN: begin
          q_d  = q_q - ONE;
          tc_d = ~|q_q;
        end
        MODE_LOAD: q_d = load_val;
        default:   q_d = q_q;
      endcase
    end
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= Q_RESET;
      tc_q  <= 1'b0;
      chg_q <= '0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Bench for t_ff_bank: directed scenarios plus randomized run against an arithmetic reference model.
module tb_t_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t = 4'd0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q0, chg0, q6, chg6;
  logic       tc0, tc6;
  logic [0:0] q1, chg1;
  logic       tc1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: instance 0 (W4, RST 0), 1 (W4, RST 6), 2 (W1, RST 0)
  int wid[3] = '{4, 4, 1};
  int rv[3]  = '{0, 6, 0};
  int m_q[3], m_tc[3], m_chg[3];

  always #5 clk = ~clk;

  t_ff_bank #(.WIDTH(4), .RST_VAL(32'd0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load_val(load_val),
    .q(q0), .tc(tc0), .chg(chg0));

  t_ff_bank #(.WIDTH(4), .RST_VAL(32'd6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load_val(load_val),
    .q(q6), .tc(tc6), .chg(chg6));

  t_ff_bank #(.WIDTH(1), .RST_VAL(32'd0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[0:0]), .load_val(load_val[0:0]),
    .q(q1), .tc(tc1), .chg(chg1));

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int md, nq;
      md = 1 << wid[k];
      nq = m_q[k];
      m_tc[k] = 0;
      if (rst) begin
        nq = rv[k];
      end else if (en) begin
        case (mode)
          2'd0: nq = m_q[k] ^ (int'(t) % md);
          2'd1: begin nq = (m_q[k] + 1) % md;      m_tc[k] = (m_q[k] == md - 1) ? 1 : 0; end
          2'd2: begin nq = (m_q[k] + md - 1) % md; m_tc[k] = (m_q[k] == 0) ? 1 : 0; end
          default: nq = int'(load_val) % md;
        endcase
      end
      m_chg[k] = rst ? 0 : (nq ^ m_q[k]);
      m_q[k]   = nq;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b01;
    tick(); tick();
    n_tests++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL reset_q got %b exp 0000", q0); end
    n_tests++; if (tc0 !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b exp 0", tc0); end
    n_tests++; if (chg0 !== 4'b0000) begin n_fail++; $display("FAIL reset_chg got %b exp 0000", chg0); end
    n_tests++; if (q6 !== 4'b0110) begin n_fail++; $display("FAIL reset_q_rstval got %b exp 0110", q6); end
    rst = 1'b0;
  endtask

  task automatic test_toggle();
    mode = 2'b00; t = 4'b0101;
    tick();
    n_tests++; if (q0 !== 4'b0101) begin n_fail++; $display("FAIL toggle_q1 got %b exp 0101", q0); end
    n_tests++; if (chg0 !== 4'b0101) begin n_fail++; $display("FAIL toggle_chg1 got %b exp 0101", chg0); end
    tick();
    n_tests++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL toggle_q2 got %b exp 0000", q0); end
    t = 4'b0000;
    tick();
    n_tests++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL toggle_hold_q got %b exp 0000", q0); end
    n_tests++; if (chg0 !== 4'b0000) begin n_fail++; $display("FAIL toggle_hold_chg got %b exp 0000", chg0); end
  endtask

  task automatic test_up_wrap();
    mode = 2'b11; load_val = 4'b1110; t = 4'b1111;
    tick();
    mode = 2'b01;
    tick();
    n_tests++; if (q0 !== 4'b1111) begin n_fail++; $display("FAIL up_q1 got %b exp 1111", q0); end
    n_tests++; if (tc0 !== 1'b0) begin n_fail++; $display("FAIL up_tc1 got %b exp 0", tc0); end
    tick();
    n_tests++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL up_wrap_q got %b exp 0000", q0); end
    n_tests++; if (tc0 !== 1'b1) begin n_fail++; $display("FAIL up_wrap_tc got %b exp 1", tc0); end
    n_tests++; if (chg0 !== 4'b1111) begin n_fail++; $display("FAIL up_wrap_chg got %b exp 1111", chg0); end
    tick();
    n_tests++; if (q0 !== 4'b0001) begin n_fail++; $display("FAIL up_q3 got %b exp 0001", q0); end
    n_tests++; if (tc0 !== 1'b0) begin n_fail++; $display("FAIL up_tc3 got %b exp 0", tc0); end
  endtask

  task automatic test_down_wrap();
    mode = 2'b11; load_val = 4'b0000;
    tick();
    n_tests++; if (tc0 !== 1'b0) begin n_fail++; $display("FAIL load_zero_tc got %b exp 0", tc0); end
    mode = 2'b10;
    tick();
    n_tests++; if (q0 !== 4'b1111) begin n_fail++; $display("FAIL down_wrap_q got %b exp 1111", q0); end
    n_tests++; if (tc0 !== 1'b1) begin n_fail++; $display("FAIL down_wrap_tc got %b exp 1", tc0); end
    mode = 2'b01;
    tick();
    n_tests++; if (q0 !== 4'b0000) begin n_fail++; $display("FAIL dir_change_q got %b exp 0000", q0); end
    n_tests++; if (tc0 !== 1'b1) begin n_fail++; $display("FAIL dir_change_tc got %b exp 1", tc0); end
  endtask

  task automatic test_load_hold();
    mode = 2'b11; load_val = 4'b1010;
    tick();
    n_tests++; if (q0 !== 4'b1010) begin n_fail++; $display("FAIL load_q got %b exp 1010", q0); end
    n_tests++; if (chg0 !== 4'b1010) begin n_fail++; $display("FAIL load_chg got %b exp 1010", chg0); end
    en = 1'b0; mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (q0 !== 4'b1010 || tc0 !== 1'b0 || chg0 !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_%0d got q=%b tc=%b chg=%b exp q=1010 tc=0 chg=0000", i, q0, tc0, chg0);
      end
    end
    en = 1'b1; mode = 2'b11;
    tick();
    n_tests++; if (chg0 !== 4'b0000) begin n_fail++; $display("FAIL load_same_chg got %b exp 0000", chg0); end
  endtask

  task automatic test_reset_mid();
    mode = 2'b11; load_val = 4'b0010;
    tick();
    mode = 2'b01;
    tick();
    n_tests++; if (q6 !== 4'b0011) begin n_fail++; $display("FAIL mid_pre_q got %b exp 0011", q6); end
    rst = 1'b1;
    tick();
    n_tests++; if (q6 !== 4'b0110 || tc6 !== 1'b0) begin n_fail++; $display("FAIL mid_rst got q=%b tc=%b exp q=0110 tc=0", q6, tc6); end
    rst = 1'b0;
    tick();
    n_tests++; if (q6 !== 4'b0111 || tc6 !== 1'b0) begin n_fail++; $display("FAIL mid_release got q=%b tc=%b exp q=0111 tc=0", q6, tc6); end
  endtask

  task automatic test_width1();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; mode = 2'b01;
    tick();
    n_tests++; if (q1 !== 1'b1 || tc1 !== 1'b0) begin n_fail++; $display("FAIL w1_up01 got q=%b tc=%b exp q=1 tc=0", q1, tc1); end
    tick();
    n_tests++; if (q1 !== 1'b0 || tc1 !== 1'b1) begin n_fail++; $display("FAIL w1_up10 got q=%b tc=%b exp q=0 tc=1", q1, tc1); end
    mode = 2'b10;
    tick();
    n_tests++; if (q1 !== 1'b1 || tc1 !== 1'b1) begin n_fail++; $display("FAIL w1_dn01 got q=%b tc=%b exp q=1 tc=1", q1, tc1); end
    tick();
    n_tests++; if (q1 !== 1'b0 || tc1 !== 1'b0) begin n_fail++; $display("FAIL w1_dn10 got q=%b tc=%b exp q=0 tc=0", q1, tc1); end
  endtask

  task automatic test_random();
    logic [3:0] oq[3], oc[3];
    logic       ot[3];
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 24) == 0);
      en       = ($urandom_range(0, 4) != 0);
      mode     = 2'($urandom_range(0, 3));
      t        = 4'($urandom);
      load_val = 4'($urandom);
      tick();
      oq = '{q0, q6, {3'b0, q1}};
      oc = '{chg0, chg6, {3'b0, chg1}};
      ot = '{tc0, tc6, tc1};
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (oq[k] !== 4'(m_q[k]) || ot[k] !== m_tc[k][0] || oc[k] !== 4'(m_chg[k])) begin
          n_fail++;
          $display("FAIL rand_%0d_inst%0d got q=%h tc=%b chg=%h exp q=%h tc=%0d chg=%h",
                   n, k, oq[k], ot[k], oc[k], m_q[k], m_tc[k], m_chg[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_wrap();
    test_load_hold();
    test_reset_mid();
    test_width1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
